// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int MIN_DIV = 2;

  // Channel-select width; a single-channel build still needs a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(MIN_DIV)) ? 32'(MIN_DIV) : d;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: down-counter period timer with glitch-free divisor swap.
// Optional CLKDIV_PHASE_SYNC_EN adds sync_req to restart the phase immediately.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = 27,
  parameter int DEF_DIV = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             sync_req,
`endif
  output logic             clk_div,
  output logic             tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] act_div;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] lo_cnt;
  logic             pend;
  logic             tc;

  // rem counts D-1 down to 0; the square wave is low for the last D>>1 counts,
  // which leaves odd divisors one cycle longer high than low.
  assign lo_cnt = act_div >> 1;
  assign tc     = (rem == '0);
  assign busy   = pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      act_div  <= DIV_W'(DEF_DIV);
      pend_div <= '0;
      pend     <= 1'b0;
      rem      <= DIV_W'(DEF_DIV - 1);
      clk_div  <= 1'b0;
      tick     <= 1'b0;
    end
`ifdef CLKDIV_PHASE_SYNC_EN
    else if (sync_req) begin
      if (pend) begin
        act_div <= pend_div;
        rem     <= pend_div - ONE;
      end else begin
        rem     <= act_div - ONE;
      end
      pend    <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
      if (wr) begin
        pend_div <= DIV_W'(clamp_div(32'(wr_div)));
        pend     <= 1'b1;
      end
    end
`endif
    else begin
      if (en) begin
        tick    <= tc;
        clk_div <= (rem >= lo_cnt);
        if (tc) begin
          if (pend) begin
            act_div <= pend_div;
            rem     <= pend_div - ONE;
            pend    <= 1'b0;
          end else begin
            rem     <= act_div - ONE;
          end
        end else begin
          rem <= rem - ONE;
        end
      end else begin
        tick <= 1'b0;
        if (pend) begin
          act_div <= pend_div;
          rem     <= pend_div - ONE;
          pend    <= 1'b0;
          clk_div <= 1'b0;
        end
      end
      // wr is only granted while pend is clear, so it never races the apply above.
      if (wr) begin
        pend_div <= DIV_W'(clamp_div(32'(wr_div)));
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_multi.sv
// NCH independent programmable dividers; top holds only cfg decode and ready mux.
// Optional CLKDIV_PHASE_SYNC_EN adds a sync_req input that phase-aligns all channels.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter  int NCH     = 4,
  parameter  int DIV_W   = 27,
  parameter  int DEF_DIV = 100000000,
  localparam int CH_W    = ch_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
`ifdef CLKDIV_PHASE_SYNC_EN
  input  logic             sync_req,
`endif
  output logic [NCH-1:0]   clk_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy
);

  logic [31:0] ch_idx;
  logic        ch_ok;

  assign ch_idx = 32'(cfg_ch);
  assign ch_ok  = (ch_idx < 32'(NCH));

  // Writes to a non-existent channel are accepted and silently dropped.
  always_comb begin
    cfg_ready = 1'b1;
    if (ch_ok) cfg_ready = ~busy[cfg_ch];
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic wr;
    assign wr = cfg_valid & cfg_ready & ch_ok & (ch_idx == 32'(i));

    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en[i]),
      .wr       (wr),
      .wr_div   (cfg_div),
`ifdef CLKDIV_PHASE_SYNC_EN
      .sync_req (sync_req),
`endif
      .clk_div  (clk_div[i]),
      .tick     (tick[i]),
      .busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboarded bench for clkdiv_multi: a cycle model pushes expected outputs each edge.
module tb_clkdiv_multi;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int DEF = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [NCH-1:0] en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_ch;
  logic [DW-1:0] cfg_div;
  logic [NCH-1:0] clk_div, tick, busy;

  // Three-channel instance, used only to reach an out-of-range channel select.
  logic          cfg_valid3;
  logic          cfg_ready3;
  logic [1:0]    cfg_ch3;
  logic [DW-1:0] cfg_div3;
  logic [2:0]    clk_div3, tick3, busy3;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [NCH-1:0] c;
    logic [NCH-1:0] t;
    logic [NCH-1:0] b;
  } obs_t;

  obs_t exp_q[$];

  always #5 clk = ~clk;

  clkdiv_multi #(.NCH(NCH), .DIV_W(DW), .DEF_DIV(DEF)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_req(1'b0),
`endif
    .clk_div(clk_div), .tick(tick), .busy(busy)
  );

  clkdiv_multi #(.NCH(3), .DIV_W(DW), .DEF_DIV(DEF)) dut3 (
    .clk(clk), .rst(rst), .en(3'b000), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3),
`ifdef CLKDIV_PHASE_SYNC_EN
    .sync_req(1'b0),
`endif
    .clk_div(clk_div3), .tick(tick3), .busy(busy3)
  );

  // Reference model written in the up-counter form of the behaviour description.
  int m_cnt[NCH], m_act[NCH], m_pdiv[NCH];
  bit m_pend[NCH], m_clk[NCH], m_tick[NCH];

  always @(posedge clk) begin
    obs_t e;
    for (int i = 0; i < NCH; i++) begin
      bit wr_i;
      int d;
      wr_i = cfg_valid && (int'(cfg_ch) == i) && !m_pend[i];
      if (rst) begin
        m_cnt[i] = 0; m_act[i] = DEF; m_pdiv[i] = 0;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        if (en[i]) begin
          d = m_act[i];
          m_tick[i] = (m_cnt[i] == d - 1);
          m_clk[i]  = (m_cnt[i] < ((d + 1) >> 1));
          if (m_cnt[i] == d - 1) begin
            m_cnt[i] = 0;
            if (m_pend[i]) begin m_act[i] = m_pdiv[i]; m_pend[i] = 0; end
          end else begin
            m_cnt[i]++;
          end
        end else begin
          m_tick[i] = 0;
          if (m_pend[i]) begin
            m_act[i] = m_pdiv[i]; m_pend[i] = 0; m_cnt[i] = 0; m_clk[i] = 0;
          end
        end
        if (wr_i) begin
          m_pdiv[i] = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
          m_pend[i] = 1;
        end
      end
      e.c[i] = m_clk[i]; e.t[i] = m_tick[i]; e.b[i] = m_pend[i];
    end
    exp_q.push_back(e);
  end

  // Advances one edge and hands back the model's expectation for it.
  task automatic next_edge(output obs_t ev, output bit have);
    @(posedge clk);
    #1;
    have = (exp_q.size() == 1);
    ev = '0;
    if (exp_q.size() > 0) ev = exp_q.pop_front();
    exp_q.delete();
  endtask

  task automatic test_reset;
    obs_t ev; bit have; int ticks0;
    rst = 1'b1; en = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    cfg_valid3 = 1'b0; cfg_ch3 = '0; cfg_div3 = '0;
    for (int k = 0; k < 3; k++) begin
      next_edge(ev, have);
      vectors++;
      if (!have || {clk_div, tick, busy} !== 12'h000) begin
        miscompares++;
        $display("FAIL reset_out: got c=%b t=%b b=%b want all 0", clk_div, tick, busy);
      end
    end
    rst = 1'b0; en = 4'b1111;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready: got %b want 1", cfg_ready);
    end
    ticks0 = 0;
    for (int k = 0; k < 30; k++) begin
      next_edge(ev, have);
      vectors++;
      if (!have || {clk_div, tick, busy} !== ev) begin
        miscompares++;
        $display("FAIL reset_sb edge %0d: got %b/%b/%b want %b/%b/%b", k + 1,
                 clk_div, tick, busy, ev.c, ev.t, ev.b);
      end
      vectors++;
      if (clk_div !== {NCH{k % 10 < 5}} || tick !== {NCH{k % 10 == 9}}) begin
        miscompares++;
        $display("FAIL reset_wave edge %0d: got c=%b t=%b", k + 1, clk_div, tick);
      end
      if (tick[0]) ticks0++;
    end
    vectors++;
    if (ticks0 != 3) begin
      miscompares++; $display("FAIL reset_ticks: got %0d want 3", ticks0);
    end
  endtask

  task automatic test_mid_change;
    obs_t ev; bit have; int low_cnt; bit cleared;
    for (int k = 0; k < 3; k++) next_edge(ev, have);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd4;
    #1;
    vectors++;
    if (cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL mid_ready_pre: got %b want 1", cfg_ready);
    end
    next_edge(ev, have);
    cfg_valid = 1'b0;
    low_cnt = 0; cleared = 0;
    for (int k = 0; k < 20 && !cleared; k++) begin
      #1;
      if (cfg_ready === 1'b0) low_cnt++;
      next_edge(ev, have);
      vectors++;
      if (!have || {clk_div, tick, busy} !== ev) begin
        miscompares++;
        $display("FAIL mid_sb: got %b/%b/%b want %b/%b/%b", clk_div, tick, busy, ev.c, ev.t, ev.b);
      end
      if (busy[1] === 1'b0) begin
        cleared = 1;
        vectors++;
        if (tick[1] !== 1'b1) begin
          miscompares++; $display("FAIL mid_old_tick: got %b want 1", tick[1]);
        end
      end
    end
    vectors++;
    if (!cleared || low_cnt != 6) begin
      miscompares++; $display("FAIL mid_busy_cycles: got %0d want 6 (cleared=%0d)", low_cnt, cleared);
    end
    for (int k = 0; k < 8; k++) begin
      next_edge(ev, have);
      vectors++;
      if (!have || tick[1] !== (k % 4 == 3) || {clk_div, tick, busy} !== ev) begin
        miscompares++; $display("FAIL mid_new_period k=%0d: got t=%b", k, tick);
      end
    end
  endtask

  // Reprograms a channel while it is stopped, then checks the restarted waveform.
  task automatic test_divisor(input int ch, input int d, input int eff, input string nm);
    obs_t ev; bit have;
    en[ch] = 1'b0;
    next_edge(ev, have);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_div = 8'(d);
    next_edge(ev, have);
    cfg_valid = 1'b0;
    vectors++;
    if (busy[ch] !== 1'b1) begin
      miscompares++; $display("FAIL %s_busy_set: got %b want 1", nm, busy[ch]);
    end
    next_edge(ev, have);
    vectors++;
    if (busy[ch] !== 1'b0 || clk_div[ch] !== 1'b0 || {clk_div, tick, busy} !== ev) begin
      miscompares++; $display("FAIL %s_apply: got c=%b b=%b", nm, clk_div, busy);
    end
    en[ch] = 1'b1;
    for (int k = 0; k < 3 * eff; k++) begin
      next_edge(ev, have);
      vectors++;
      if (!have || clk_div[ch] !== (k % eff < (eff + 1) / 2) || tick[ch] !== (k % eff == eff - 1)
          || {clk_div, tick, busy} !== ev) begin
        miscompares++;
        $display("FAIL %s_wave k=%0d: got c=%b t=%b want c=%b t=%b", nm, k, clk_div, tick, ev.c, ev.t);
      end
    end
  endtask

  task automatic test_bad_channel;
    obs_t ev; bit have;
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd3;
    #1;
    vectors++;
    if (cfg_ready3 !== 1'b1) begin
      miscompares++; $display("FAIL badch_ready: got %b want 1", cfg_ready3);
    end
    next_edge(ev, have);
    cfg_valid3 = 1'b0;
    next_edge(ev, have);
    vectors++;
    if (busy3 !== 3'b000 || clk_div3 !== 3'b000 || tick3 !== 3'b000) begin
      miscompares++; $display("FAIL badch_effect: got b=%b c=%b t=%b want 0", busy3, clk_div3, tick3);
    end
  endtask

  task automatic test_hold_reset;
    obs_t ev; bit have; logic held;
    next_edge(ev, have);
    en[0] = 1'b0;
    next_edge(ev, have);
    held = clk_div[0];
    vectors++;
    if (held !== ev.c[0]) begin
      miscompares++; $display("FAIL hold_start: got %b want %b", held, ev.c[0]);
    end
    for (int k = 0; k < 6; k++) begin
      next_edge(ev, have);
      vectors++;
      if (clk_div[0] !== held || tick[0] !== 1'b0 || {clk_div, tick, busy} !== ev) begin
        miscompares++; $display("FAIL hold_k%0d: got c=%b t=%b", k, clk_div[0], tick[0]);
      end
    end
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;
    next_edge(ev, have);
    cfg_valid = 1'b0;
    #1;
    vectors++;
    if (busy[1] !== 1'b1 || cfg_ready !== 1'b0) begin
      miscompares++; $display("FAIL hold_pend: got b=%b r=%b want 1/0", busy[1], cfg_ready);
    end
    rst = 1'b1;
    next_edge(ev, have);
    rst = 1'b0; en = '0;
    #1;
    vectors++;
    if ({clk_div, tick, busy} !== 12'h000 || cfg_ready !== 1'b1 || {clk_div, tick, busy} !== ev) begin
      miscompares++;
      $display("FAIL hold_rst: got c=%b t=%b b=%b r=%b", clk_div, tick, busy, cfg_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mid_change();
    test_divisor(0, 4, 4, "even");
    test_divisor(2, 5, 5, "odd");
    test_divisor(3, 0, 2, "clamp");
    test_bad_channel();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
